// File: rtl/full_adder_cell.sv
// One-bit full adder cell: sum and majority carry.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with combinational result and a registered copy.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q
);

    logic [WIDTH:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (Sum[i]),
            .co (c[i+1])
        );
    end

    assign Cout = c[WIDTH];

    // Reset only touches the pipelined copy; Sum/Cout always follow inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum_q  <= '0;
            Cout_q <= 1'b0;
        end else begin
            Sum_q  <= Sum;
            Cout_q <= Cout;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, c1;
    logic       s1, co1, sq1, coq1;
    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] s8, sq8;
    logic       co8, coq8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .A      (a1),
        .B      (b1),
        .Cin    (c1),
        .Sum    (s1),
        .Cout   (co1),
        .Sum_q  (sq1),
        .Cout_q (coq1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .A      (a8),
        .B      (b8),
        .Cin    (c8),
        .Sum    (s8),
        .Cout   (co8),
        .Sum_q  (sq8),
        .Cout_q (coq8)
    );

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [8:0] want;
        logic [8:0] prev;
        logic [2:0] v;

        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;

        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

        @(posedge clk); #1;
        chk("rst_sq1", {8'h0, sq1}, 9'h0);
        chk("rst_coq1", {8'h0, coq1}, 9'h0);
        chk("rst_sq8", {1'b0, sq8}, 9'h0);
        chk("rst_coq8", {8'h0, coq8}, 9'h0);
        chk("zero8", {co8, s8}, 9'h000);

        // exhaustive 1-bit truth table, 10 time units per vector
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, c1} = v;
            #1;
            chk($sformatf("tt_sum_%0d", i), {8'h0, s1}, {8'h0, exp_s[i]});
            chk($sformatf("tt_cout_%0d", i), {8'h0, co1}, {8'h0, exp_c[i]});
            #9;
        end

        // combinational path ignores reset
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        #1;
        chk("ind_sum", {8'h0, s1}, 9'h0);
        chk("ind_cout", {8'h0, co1}, 9'h1);
        @(posedge clk); #1;
        chk("ind_sq", {8'h0, sq1}, 9'h0);
        chk("ind_coq", {8'h0, coq1}, 9'h0);

        // registered path
        @(negedge clk);
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        #1;
        chk("pre_sq", {8'h0, sq1}, 9'h0);
        chk("pre_coq", {8'h0, coq1}, 9'h0);
        @(posedge clk); #1;
        chk("reg_sq", {8'h0, sq1}, 9'h0);
        chk("reg_coq", {8'h0, coq1}, 9'h1);

        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        chk("one_sq", {8'h0, sq1}, 9'h1);
        chk("one_coq", {8'h0, coq1}, 9'h0);

        // synchronous reset mid-stream
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("srst_hold", {8'h0, sq1}, 9'h1);
        @(posedge clk); #1;
        chk("srst_sq", {8'h0, sq1}, 9'h0);
        chk("srst_coq", {8'h0, coq1}, 9'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_sq", {8'h0, sq1}, 9'h1);

        // 8-bit ripple cases
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        #1;
        chk("rip_ff", {co8, s8}, 9'h100);
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        #1;
        chk("rip_7f", {co8, s8}, 9'h080);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1;
        chk("all_ones", {co8, s8}, 9'h1FF);
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        #1;
        chk("all_zero", {co8, s8}, 9'h000);

        // random vectors, combinational and one-cycle-delayed
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            want = {1'b0, a8} + {1'b0, b8} + {8'h0, c8};
            #1;
            chk("rnd_comb", {co8, s8}, want);
            prev = want;
            @(posedge clk); #1;
            chk("rnd_reg", {coq8, sq8}, prev);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
